// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage at the head of the pipeline. It owns the program
// counter, keeps at most one word read outstanding to instruction memory and
// buffers returned words in a 2-entry queue toward Decode. A taken branch
// reported by Execute redirects the PC and squashes every queued and
// in-flight instruction.
//
// Parameters
//   RESET_PC      word-aligned PC loaded at reset
//
// Ports
//   clk           rising-edge clock for all state
//   rst_n         synchronous, active-low reset
//   imem_req      read request, held until imem_rvalid
//   imem_addr     word-aligned read address, stable while imem_req=1
//   imem_rdata    read data, valid with imem_rvalid
//   imem_rvalid   one-cycle response strobe
//   instr         instruction at the head of the queue
//   instr_pc      byte address of instr
//   instr_valid   instr/instr_pc valid (gated off while branch_taken=1)
//   decode_ready  Decode consumes the head when instr_valid & decode_ready
//   branch_taken  taken branch in Execute (level; first cycle redirects)
//   branch_delta  signed byte offset of the taken branch
//   ex_pc         address of the instruction currently in Execute
// ----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        decode_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_delta,
  input  logic [31:0] ex_pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FULL,
    S_DROP,
    S_FROZEN
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] imem_addr_reg;
  logic        imem_req_reg;
  logic [1:0]  count_reg;
  logic        branch_prev_reg;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_inc;
  logic        pop;
  logic        push;
  logic [1:0]  count_next;

  // Queue storage: entry 0 is the head and drives the outputs directly.
  logic [1:0]  q_we;
  logic [31:0] q_instr_next [2];
  logic [31:0] q_pc_next    [2];
  logic [31:0] q_instr      [2];
  logic [31:0] q_pc         [2];

  // Only the rising edge of branch_taken redirects; a held level is a freeze.
  assign redirect = branch_taken & ~branch_prev_reg;

  // Branch target relative to the Execute PC, forced to a word boundary.
  assign target = (ex_pc + 32'd8 + branch_delta) & ~32'h3;

  assign pc_inc = pc_reg + 32'd4;

  // The branch gate is combinational so Decode never sees a squashed word
  // in the cycle the branch is reported.
  assign instr_valid = (count_reg != 2'd0) & ~branch_taken;
  assign pop         = instr_valid & decode_ready;
  assign push        = (state_reg == S_WAIT) & imem_rvalid;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Per-entry write enables. The head only changes when a word actually
  // moves into it, so after the last pop it keeps showing the last word
  // (instr/instr_pc hold while instr_valid=0).
  always_comb begin
    q_we            = 2'b00;
    q_instr_next[0] = imem_rdata;
    q_pc_next[0]    = pc_reg;
    q_instr_next[1] = imem_rdata;
    q_pc_next[1]    = pc_reg;
    if (!redirect) begin
      if (pop) begin
        if (count_reg == 2'd2) begin
          // Tail advances to head; a same-cycle push refills the tail.
          q_we[0]         = 1'b1;
          q_instr_next[0] = q_instr[1];
          q_pc_next[0]    = q_pc[1];
          q_we[1]         = push;
        end else begin
          // Single entry leaving; a same-cycle push lands straight in head.
          q_we[0] = push;
        end
      end else if (push) begin
        if (count_reg == 2'd0) begin
          q_we[0] = 1'b1;
        end else begin
          q_we[1] = 1'b1;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [31:0] entry_instr_reg;
      logic [31:0] entry_pc_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          entry_instr_reg <= '0;
          entry_pc_reg    <= '0;
        end else if (q_we[gi]) begin
          entry_instr_reg <= q_instr_next[gi];
          entry_pc_reg    <= q_pc_next[gi];
        end
      end

      assign q_instr[gi] = entry_instr_reg;
      assign q_pc[gi]    = entry_pc_reg;
    end
  endgenerate

  assign instr     = q_instr[0];
  assign instr_pc  = q_pc[0];
  assign imem_req  = imem_req_reg;
  assign imem_addr = imem_addr_reg;

  // Control FSM. imem_req/imem_addr are registered alongside the state so
  // they are glitch-free and the address cannot move mid-request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      pc_reg          <= RESET_PC;
      imem_addr_reg   <= RESET_PC;
      imem_req_reg    <= 1'b0;
      count_reg       <= 2'd0;
      branch_prev_reg <= 1'b0;
    end else begin
      branch_prev_reg <= branch_taken;

      if (redirect) begin
        pc_reg    <= target;
        count_reg <= 2'd0;
        if (imem_req_reg && !imem_rvalid) begin
          // A read is still in flight: keep presenting it until its
          // response arrives, then throw that response away.
          state_reg    <= S_DROP;
          imem_req_reg <= 1'b1;
        end else begin
          state_reg    <= S_FROZEN;
          imem_req_reg <= 1'b0;
        end
      end else begin
        count_reg <= count_next;
        case (state_reg)
          S_IDLE: begin
            state_reg     <= S_WAIT;
            imem_req_reg  <= 1'b1;
            imem_addr_reg <= pc_reg;
          end

          S_WAIT: begin
            if (imem_rvalid) begin
              pc_reg <= pc_inc;
              if (count_next == 2'd2) begin
                state_reg    <= S_FULL;
                imem_req_reg <= 1'b0;
              end else begin
                // Back-to-back: next request goes out in the following cycle.
                imem_addr_reg <= pc_inc;
              end
            end
          end

          S_FULL: begin
            if (count_next != 2'd2) begin
              state_reg     <= S_WAIT;
              imem_req_reg  <= 1'b1;
              imem_addr_reg <= pc_reg;
            end
          end

          S_DROP: begin
            if (imem_rvalid) begin
              if (branch_taken) begin
                state_reg    <= S_FROZEN;
                imem_req_reg <= 1'b0;
              end else begin
                state_reg     <= S_WAIT;
                imem_req_reg  <= 1'b1;
                imem_addr_reg <= pc_reg;
              end
            end
          end

          S_FROZEN: begin
            if (!branch_taken) begin
              state_reg     <= S_WAIT;
              imem_req_reg  <= 1'b1;
              imem_addr_reg <= pc_reg;
            end
          end

          default: begin
            state_reg    <= S_IDLE;
            imem_req_reg <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage with RESET_PC=0x100. A small memory
// responder returns addr ^ 0xA5A5_0000 after a programmable latency; words
// consumed by Decode are compared in order against a hand-written expected
// list, and every other check is a directed comparison at a fixed cycle.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        decode_ready;
  logic        branch_taken;
  logic [31:0] branch_delta;
  logic [31:0] ex_pc;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_rvalid  (imem_rvalid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .decode_ready (decode_ready),
    .branch_taken (branch_taken),
    .branch_delta (branch_delta),
    .ex_pc        (ex_pc)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Memory responder state
  int          mem_lat     = 1;
  bit          mem_busy    = 1'b0;
  int          mem_cnt     = 0;
  logic [31:0] mem_addr    = '0;
  int          mem_accepts = 0;

  // Expected Decode stream: {instr, pc}
  logic [63:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle. Decode consumption is scored just before the edge;
  // the memory responder updates imem_rvalid/imem_rdata 1ns after the edge.
  task automatic tick();
    logic [63:0] e;
    #1;
    if (rst_n && instr_valid && decode_ready) begin
      $display("decode: instr=%h pc=%h", instr, instr_pc);
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL decode_extra: observed instr %h pc %h expected none", instr, instr_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("decode", {instr, instr_pc}, e);
      end
    end
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_addr ^ 32'hA5A5_0000;
        mem_busy    = 1'b0;
        $display("mem: response addr=%h data=%h", mem_addr, imem_rdata);
      end else if (imem_req) begin
        check("addr_stable", {32'h0, imem_addr}, {32'h0, mem_addr});
      end
    end
    if (!mem_busy && !imem_rvalid && imem_req) begin
      mem_busy = 1'b1;
      mem_cnt  = mem_lat;
      mem_addr = imem_addr;
      mem_accepts++;
      $display("mem: request addr=%h", imem_addr);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {63'h0, imem_req},    64'h0);
    check({tag, "_addr"},  {32'h0, imem_addr},   64'h100);
    check({tag, "_valid"}, {63'h0, instr_valid}, 64'h0);
    check({tag, "_instr"}, {instr, instr_pc},    64'h0);
  endtask

  // Two reset edges; returns in the first cycle with rst_n high (state IDLE).
  task automatic do_reset();
    check("drain", exp_q.size(), 0);
    rst_n       = 1'b0;
    mem_busy    = 1'b0;
    imem_rvalid = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");
    rst_n       = 1'b1;
    mem_accepts = 0;
  endtask

  initial begin
    int acc0;
    rst_n        = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = '0;
    decode_ready = 1'b1;
    branch_taken = 1'b0;
    branch_delta = '0;
    ex_pc        = '0;

    // ---- 1: streaming with 1-cycle memory, Decode always ready ----
    mem_lat = 1;
    do_reset();
    tick();                                   // C1: request 0x100
    check("t1_req_c1",  {63'h0, imem_req}, 64'h1);
    check("t1_addr_c1", {32'h0, imem_addr}, 64'h100);
    tick();                                   // C2: response
    tick();                                   // C3: head valid, request 0x104
    check("t1_valid_c3", {63'h0, instr_valid}, 64'h1);
    check("t1_addr_c3",  {32'h0, imem_addr}, 64'h104);
    exp_q.push_back({32'hA5A5_0100, 32'h0000_0100});
    tick();                                   // C4: queue empty again
    check("t1_valid_c4", {63'h0, instr_valid}, 64'h0);
    check("t1_hold_c4",  {instr, instr_pc}, {32'hA5A5_0100, 32'h0000_0100});
    tick();                                   // C5
    check("t1_addr_c5", {32'h0, imem_addr}, 64'h108);
    exp_q.push_back({32'hA5A5_0104, 32'h0000_0104});
    tick();
    tick();                                   // C7
    exp_q.push_back({32'hA5A5_0108, 32'h0000_0108});
    tick();

    // ---- 2: Decode stalled from reset ----
    decode_ready = 1'b0;
    do_reset();
    tick(); tick(); tick(); tick();
    tick();                                   // C5: FULL
    check("t2_req_full",  {63'h0, imem_req}, 64'h0);
    check("t2_head_full", {instr, instr_pc}, {32'hA5A5_0100, 32'h0000_0100});
    tick();                                   // C6
    check("t2_req_c6",   {63'h0, imem_req}, 64'h0);
    check("t2_pc_c6",    {32'h0, instr_pc}, 64'h100);
    tick();                                   // C7
    check("t2_two_reqs", mem_accepts, 2);
    decode_ready = 1'b1;
    exp_q.push_back({32'hA5A5_0100, 32'h0000_0100});
    tick();                                   // C8
    decode_ready = 1'b0;
    check("t2_req_c8",  {63'h0, imem_req}, 64'h1);
    check("t2_addr_c8", {32'h0, imem_addr}, 64'h108);
    check("t2_head_c8", {instr, instr_pc}, {32'hA5A5_0104, 32'h0000_0104});
    tick();                                   // C9: response 0x108
    tick();                                   // C10: FULL with 0x104, 0x108

    // ---- 3: one-cycle branch with two queued entries ----
    check("t3_full_req", {63'h0, imem_req}, 64'h0);
    branch_taken = 1'b1;
    ex_pc        = 32'h0000_0200;
    branch_delta = 32'hFFFF_FFF0;
    #1;
    check("t3_gate", {63'h0, instr_valid}, 64'h0);
    tick();                                   // C11: frozen
    branch_taken = 1'b0;
    #1;
    check("t3_flush_valid", {63'h0, instr_valid}, 64'h0);
    check("t3_frozen_req",  {63'h0, imem_req}, 64'h0);
    tick();                                   // C12: request to target
    check("t3_req",    {63'h0, imem_req}, 64'h1);
    check("t3_target", {32'h0, imem_addr}, 64'h1F8);
    decode_ready = 1'b1;
    tick();
    tick();                                   // C14
    check("t3_valid", {63'h0, instr_valid}, 64'h1);
    exp_q.push_back({32'hA5A5_01F8, 32'h0000_01F8});
    tick();

    // ---- 4: branch while 0x40 is outstanding on 3-cycle memory ----
    mem_lat = 3;
    do_reset();
    branch_taken = 1'b1;                      // C0: redirect from IDLE to 0x40
    ex_pc        = 32'h0000_0038;
    branch_delta = 32'h0;
    tick();                                   // C1
    branch_taken = 1'b0;
    check("t4_frozen_req", {63'h0, imem_req}, 64'h0);
    tick();                                   // C2
    check("t4_addr40", {32'h0, imem_addr}, 64'h40);
    tick();                                   // C3
    branch_taken = 1'b1;
    ex_pc        = 32'h0000_0300;
    branch_delta = 32'h0000_0010;
    tick();                                   // C4: DROP
    branch_taken = 1'b0;
    check("t4_drop_req",  {63'h0, imem_req}, 64'h1);
    check("t4_drop_addr", {32'h0, imem_addr}, 64'h40);
    tick();                                   // C5: stale response
    check("t4_drop_addr_c5", {32'h0, imem_addr}, 64'h40);
    tick();                                   // C6
    check("t4_new_addr", {32'h0, imem_addr}, 64'h318);
    check("t4_no_stale", {63'h0, instr_valid}, 64'h0);
    tick(); tick(); tick();                   // C9: response 0x318
    tick();                                   // C10
    check("t4_valid", {63'h0, instr_valid}, 64'h1);
    exp_q.push_back({32'hA5A5_0318, 32'h0000_0318});
    tick();

    // ---- 5: branch held 3 cycles, same-cycle response discarded ----
    mem_lat = 1;
    do_reset();
    tick();                                   // C1: request 0x100
    tick();                                   // C2: response + branch
    branch_taken = 1'b1;
    ex_pc        = 32'h0000_0010;
    branch_delta = 32'h0000_0020;
    acc0         = mem_accepts;
    #1;
    check("t5_gate", {63'h0, instr_valid}, 64'h0);
    tick();                                   // C3
    ex_pc        = 32'h0000_0999;
    branch_delta = 32'h0000_1234;
    check("t5_req_c3", {63'h0, imem_req}, 64'h0);
    tick();                                   // C4
    branch_delta = 32'hFFFF_0000;
    check("t5_req_c4", {63'h0, imem_req}, 64'h0);
    tick();                                   // C5
    branch_taken = 1'b0;
    check("t5_req_c5",      {63'h0, imem_req}, 64'h0);
    check("t5_no_requests", mem_accepts, acc0);
    tick();                                   // C6
    check("t5_target", {32'h0, imem_addr}, 64'h38);
    check("t5_req_c6", {63'h0, imem_req}, 64'h1);
    tick();
    tick();                                   // C8
    exp_q.push_back({32'hA5A5_0038, 32'h0000_0038});
    tick();

    // ---- 6: reset mid-request, late response lands in IDLE ----
    mem_lat = 3;
    do_reset();
    tick();                                   // C1: request 0x100 accepted
    tick();                                   // C2
    rst_n = 1'b0;
    tick();                                   // C3: reset taken
    check_reset_outputs("t6_rst");
    tick();                                   // C4: late response, IDLE
    rst_n = 1'b1;
    check("t6_idle_req", {63'h0, imem_req}, 64'h0);
    tick();                                   // C5
    check("t6_restart_addr", {32'h0, imem_addr}, 64'h100);
    check("t6_ignored",      {63'h0, instr_valid}, 64'h0);
    tick();                                   // C6
    check("t6_ignored_c6", {63'h0, instr_valid}, 64'h0);
    tick(); tick();                           // C8: response
    tick();                                   // C9
    exp_q.push_back({32'hA5A5_0100, 32'h0000_0100});
    tick();

    // ---- 7: target alignment and PC wrap ----
    mem_lat = 1;
    do_reset();
    branch_taken = 1'b1;                      // target (FFFFFFF0+8+6)&~3
    ex_pc        = 32'hFFFF_FFF0;
    branch_delta = 32'h0000_0006;
    tick();                                   // C1
    branch_taken = 1'b0;
    tick();                                   // C2
    check("t7_target", {32'h0, imem_addr}, 64'hFFFF_FFFC);
    tick();
    tick();                                   // C4
    check("t7_wrap", {32'h0, imem_addr}, 64'h0);
    exp_q.push_back({32'h5A5A_FFFC, 32'hFFFF_FFFC});
    tick();
    tick();                                   // C6
    exp_q.push_back({32'hA5A5_0000, 32'h0000_0000});
    tick();
    check("final_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish within 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage at the head of the pipeline, upstream of Decode. It also consumes the branch outcome that Execute produces (`global_disable` / `delta_instruction`). It owns the program counter, issues word reads to instruction memory with one request outstanding, and buffers returned words in a 2-entry output queue toward Decode. On a taken branch it redirects the PC and squashes every queued and in-flight instruction.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded at reset; must be word aligned.
- `clk`  in  1  rising-edge clock for all state.
- `rst_n`  in  1  synchronous, active-low reset.
- `imem_req`  out  1  read request; held until `imem_rvalid`.
- `imem_addr`  out  32  word-aligned read address; stable while `imem_req`=1.
- `imem_rdata`  in  32  read data; valid when `imem_rvalid`=1.
- `imem_rvalid`  in  1  one-cycle response strobe; at least one cycle after `imem_req` rises.
- `instr`  out  32  instruction to Decode.
- `instr_pc`  out  32  byte address of `instr`.
- `instr_valid`  out  1  `instr`/`instr_pc` valid.
- `decode_ready`  in  1  Decode consumes the head entry when `instr_valid` & `decode_ready`.
- `branch_taken`  in  1  Execute's `global_disable`: taken branch in Execute.
- `branch_delta`  in  32  Execute's `delta_instruction`: signed byte offset, valid while `branch_taken`=1.
- `ex_pc`  in  32  address of the instruction currently in Execute, forwarded down the pipeline.

## Operation
- Registers:
  - `pc`: next address to request.
  - Output queue: 2 entries, each holding {instr, pc}; head drives the outputs.
  - State: IDLE, WAIT, FULL, DROP, FROZEN.
- IDLE (reset state): `imem_req`=0 and `imem_rvalid` is ignored. Goes to WAIT on the next cycle.
- WAIT: `imem_req`=1, `imem_addr`=`pc`. On `imem_rvalid`:
  - push {`imem_rdata`, `pc`} into the queue;
  - `pc` <= `pc`+4, with 32-bit wrap (`32'hFFFF_FFFC` -> `0`);
  - go to FULL if the queue then holds 2 entries, otherwise stay in WAIT and issue the next request in the following cycle.
- Push and pop in the same cycle are legal; occupancy is then unchanged.
- FULL: `imem_req`=0. Return to WAIT in the cycle after a pop brings occupancy to 1.
- Redirect:
  - Occurs on the first cycle `branch_taken`=1, i.e. the cycle after it was 0 or after reset. It has priority over every other event in that cycle.
  - `pc` <= (`ex_pc` + 8 + `branch_delta`) & `~32'h3`, with the sum truncated to 32 bits.
  - The queue is emptied and any same-cycle push or pop is discarded.
  - If a request is outstanding and no `imem_rvalid` arrives that cycle, go to DROP.
  - Otherwise go to FROZEN; a same-cycle `imem_rvalid` is discarded.
- DROP: `imem_req`=1 and `imem_addr` keeps the squashed address. The response is discarded on `imem_rvalid`; then go to FROZEN if `branch_taken`=1, else WAIT.
- FROZEN:
  - `imem_req`=0 and `instr_valid`=0.
  - Held while `branch_taken`=1; no further redirects occur during the freeze, and `branch_delta`/`ex_pc` are ignored after the first cycle.
  - Goes to WAIT in the cycle after `branch_taken` falls.
- `instr_valid`=0 whenever the queue is empty or `branch_taken`=1.
- When `instr_valid`=0, `instr` and `instr_pc` hold their last values.

## Timing
- Reset values: `pc`=`RESET_PC`, queue empty, `instr_valid`=0, `instr`=0, `instr_pc`=0, `imem_req`=0, `imem_addr`=`RESET_PC`, state IDLE.
- `rst_n` low at any point, including with a request outstanding, restores these values on the next edge. A late `imem_rvalid` from the aborted request is ignored in IDLE.
- Latency:
  - First `imem_req` rises 1 cycle after `rst_n` goes high.
  - `instr_valid` rises the cycle after `imem_rvalid`.
  - With 1-cycle memory, steady throughput is one instruction every 2 cycles (request, response).
- Redirect: first request to the target is issued 1 cycle after `branch_taken` falls. If the freeze is a single cycle, that is 2 cycles after `branch_taken` rises.
- Flush visibility: `instr_valid`=0 in the same cycle `branch_taken`=1 (combinational gate), and the queue is empty from the next edge.
- Decode may hold `decode_ready`=0 indefinitely; no instruction is lost or duplicated.

## Test plan
- Reset with `RESET_PC`=`0x100`, 1-cycle memory returning addr^`0xA5A5_0000`, `decode_ready`=1 -> `imem_addr` sequence `0x100`, `0x104`, `0x108`; Decode sees (`0xA5A5_0100`, `0x100`), (`0xA5A5_0104`, `0x104`) in order.
- `decode_ready`=0 from reset -> exactly 2 requests, then `imem_req`=0 in FULL with the head stable at pc `0x100`. After `decode_ready` rises for 1 cycle, the third request goes to `0x108`.
- `branch_taken`=1 for 1 cycle with `ex_pc`=`0x200` and `branch_delta`=`0xFFFF_FFF0` while the queue holds 2 entries -> queue flushed, `instr_valid`=0, next request to `0x1F8`.
- Branch arrives while a request to `0x40` is outstanding on 3-cycle memory -> `imem_addr` held at `0x40` until `imem_rvalid`, that response is dropped, next request to the target, and no `0x40` instruction reaches Decode.
- `branch_taken` held for 3 cycles with `ex_pc`=`0x10`, `branch_delta`=`0x20` -> no requests during the freeze, then a single redirect to `0x38`. `branch_delta` changing on cycles 2-3 has no effect.
- Reset asserted mid-request, then memory responds -> response ignored, all outputs at reset values, and fetch restarts at `RESET_PC`.
